// File: rtl/alu_pkg.sv
// Shared constants for the ALU shift/multiply path: operand width and op encoding.
package alu_pkg;

    localparam int WIDTH = 8;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_SL   = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

endpackage

// File: rtl/right_shifter8.sv
// 8-bit right barrel shifter shared by arithmetic shift right and rotate right.
// Stages shift by 1/2/4; a final stage saturates to the sign fill when the
// amount is 8 or more (arithmetic mode only; rotate uses amount modulo 8).
module right_shifter8
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] amount,
    input  logic             rotate,
    output logic [WIDTH-1:0] result
);

    logic             fill;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s4;

    // Barrel stages: the bits shifted in come from the other end when rotating,
    // otherwise from the sign bit.
    always_comb begin
        fill = data[WIDTH-1];

        if (amount[0])
            s1 = rotate ? {data[0], data[7:1]} : {fill, data[7:1]};
        else
            s1 = data;

        if (amount[1])
            s2 = rotate ? {s1[1:0], s1[7:2]} : {{2{fill}}, s1[7:2]};
        else
            s2 = s1;

        if (amount[2])
            s4 = rotate ? {s2[3:0], s2[7:4]} : {{4{fill}}, s2[7:4]};
        else
            s4 = s2;

        if (!rotate && (|amount[7:3]))
            result = {WIDTH{fill}};
        else
            result = s4;
    end

endmodule

// File: rtl/alu_shift_mul_unit.sv
// Registered 8-bit multiply / shift / rotate unit with a one-cycle result latency.
module alu_shift_mul_unit
    import alu_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             OUT_VALID
);

    logic [WIDTH-1:0] mult_res;
    logic [WIDTH-1:0] sl_res;
    logic [WIDTH-1:0] rsh_res;
    logic [WIDTH-1:0] next_result;
    logic [WIDTH-1:0] sl1;
    logic [WIDTH-1:0] sl2;
    logic [WIDTH-1:0] sl4;

    right_shifter8 u_rsh (
        .data   (DATA1),
        .amount (DATA2),
        .rotate (OP == OP_ROR),
        .result (rsh_res)
    );

    // Shift-and-add multiplier; only the low byte is kept, which is the same
    // for signed and unsigned operands.
    always_comb begin
        mult_res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (DATA2[i])
                mult_res = mult_res + (DATA1 << i);
        end
    end

    // Left barrel shifter, zero fill, cleared for amounts of 8 or more.
    always_comb begin
        sl1    = DATA2[0] ? {DATA1[6:0], 1'b0} : DATA1;
        sl2    = DATA2[1] ? {sl1[5:0], 2'b00}  : sl1;
        sl4    = DATA2[2] ? {sl2[3:0], 4'h0}   : sl2;
        sl_res = (|DATA2[7:3]) ? '0 : sl4;
    end

    // Operation select.
    always_comb begin
        next_result = mult_res;
        case (OP)
            OP_MULT: next_result = mult_res;
            OP_SL:   next_result = sl_res;
            OP_SRA:  next_result = rsh_res;
            OP_ROR:  next_result = rsh_res;
            default: next_result = mult_res;
        endcase
    end

    // Output register; ZERO tracks the value being loaded, not the old RESULT.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            RESULT    <= '0;
            ZERO      <= 1'b1;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= IN_VALID;
            if (IN_VALID) begin
                RESULT <= next_result;
                ZERO   <= (next_result == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_shift_mul_unit.sv
// Directed bench for alu_shift_mul_unit: vector table plus reset/pipeline sequences.
module tb_alu_shift_mul_unit;
    import alu_pkg::*;

    logic       CLK;
    logic       RESET;
    logic       IN_VALID;
    logic [1:0] OP;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [7:0] RESULT;
    logic       ZERO;
    logic       OUT_VALID;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [1:0] op;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] exp_res;
        logic       exp_zero;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    alu_shift_mul_unit dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .OP        (OP),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .RESULT    (RESULT),
        .ZERO      (ZERO),
        .OUT_VALID (OUT_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] d1, input logic [7:0] d2);
        IN_VALID = v;
        OP       = op;
        DATA1    = d1;
        DATA2    = d2;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        vecs[0]  = '{OP_MULT, 8'h05, 8'h03, 8'h0F, 1'b0};
        vecs[1]  = '{OP_MULT, 8'hFE, 8'h03, 8'hFA, 1'b0};
        vecs[2]  = '{OP_MULT, 8'h10, 8'h10, 8'h00, 1'b1};
        vecs[3]  = '{OP_MULT, 8'hFF, 8'hFF, 8'h01, 1'b0};
        vecs[4]  = '{OP_SL,   8'h81, 8'd1,  8'h02, 1'b0};
        vecs[5]  = '{OP_SL,   8'h01, 8'd7,  8'h80, 1'b0};
        vecs[6]  = '{OP_SL,   8'h5A, 8'd0,  8'h5A, 1'b0};
        vecs[7]  = '{OP_SL,   8'hFF, 8'd8,  8'h00, 1'b1};
        vecs[8]  = '{OP_SL,   8'hFF, 8'd200, 8'h00, 1'b1};
        vecs[9]  = '{OP_SRA,  8'h80, 8'd2,  8'hE0, 1'b0};
        vecs[10] = '{OP_SRA,  8'h7F, 8'd3,  8'h0F, 1'b0};
        vecs[11] = '{OP_SRA,  8'h80, 8'd9,  8'hFF, 1'b0};
        vecs[12] = '{OP_SRA,  8'h40, 8'd8,  8'h00, 1'b1};
        vecs[13] = '{OP_SRA,  8'hC0, 8'd0,  8'hC0, 1'b0};
        vecs[14] = '{OP_ROR,  8'h01, 8'd1,  8'h80, 1'b0};
        vecs[15] = '{OP_ROR,  8'hA5, 8'd4,  8'h5A, 1'b0};
        vecs[16] = '{OP_ROR,  8'h01, 8'd9,  8'h80, 1'b0};
        vecs[17] = '{OP_ROR,  8'h3C, 8'd8,  8'h3C, 1'b0};
        vecs[18] = '{OP_ROR,  8'h81, 8'd3,  8'h30, 1'b0};

        // Reset held two cycles with IN_VALID high: the valid must be dropped.
        RESET = 1'b1;
        drive(1'b1, OP_MULT, 8'h05, 8'h03);
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_result", RESULT, 8'h00);
            check("reset_zero", {7'b0, ZERO}, 8'h01);
            check("reset_out_valid", {7'b0, OUT_VALID}, 8'h00);
        end
        RESET = 1'b0;
        drive(1'b0, OP_SL, 8'h00, 8'h00);
        step();
        check("post_reset_out_valid", {7'b0, OUT_VALID}, 8'h00);
        check("post_reset_result", RESULT, 8'h00);

        // Vector table, one operation per cycle with an idle cycle between.
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].d1, vecs[i].d2);
            step();
            check($sformatf("vec%0d_result", i), RESULT, vecs[i].exp_res);
            check($sformatf("vec%0d_zero", i), {7'b0, ZERO}, {7'b0, vecs[i].exp_zero});
            check($sformatf("vec%0d_out_valid", i), {7'b0, OUT_VALID}, 8'h01);
            drive(1'b0, OP_MULT, 8'hFF, 8'hFF);
            step();
            check($sformatf("vec%0d_hold", i), RESULT, vecs[i].exp_res);
            check($sformatf("vec%0d_ov_drop", i), {7'b0, OUT_VALID}, 8'h00);
        end

        // Back-to-back operations, then idle: result holds and OUT_VALID drops.
        drive(1'b1, OP_MULT, 8'h02, 8'h03);
        step();
        check("pipe0_result", RESULT, 8'h06);
        check("pipe0_out_valid", {7'b0, OUT_VALID}, 8'h01);
        drive(1'b1, OP_SL, 8'h01, 8'd2);
        step();
        check("pipe1_result", RESULT, 8'h04);
        check("pipe1_out_valid", {7'b0, OUT_VALID}, 8'h01);
        drive(1'b1, OP_ROR, 8'h02, 8'd1);
        step();
        check("pipe2_result", RESULT, 8'h01);
        check("pipe2_out_valid", {7'b0, OUT_VALID}, 8'h01);
        drive(1'b0, OP_MULT, 8'h00, 8'h00);
        step();
        check("pipe_hold_result", RESULT, 8'h01);
        check("pipe_hold_zero", {7'b0, ZERO}, 8'h00);
        check("pipe_hold_out_valid", {7'b0, OUT_VALID}, 8'h00);
        step();
        check("pipe_hold2_result", RESULT, 8'h01);

        // Zero result while idle inputs would give zero: ZERO must not change.
        drive(1'b0, OP_SL, 8'h00, 8'd9);
        step();
        check("idle_zero_hold", {7'b0, ZERO}, 8'h00);

        // Reset arriving mid-stream together with a valid operation.
        drive(1'b1, OP_MULT, 8'h07, 8'h07);
        step();
        check("mid_result", RESULT, 8'h31);
        RESET = 1'b1;
        drive(1'b1, OP_MULT, 8'h03, 8'h03);
        step();
        check("mid_reset_out_valid", {7'b0, OUT_VALID}, 8'h00);
        check("mid_reset_result", RESULT, 8'h00);
        check("mid_reset_zero", {7'b0, ZERO}, 8'h01);
        RESET = 1'b0;
        drive(1'b0, OP_MULT, 8'h00, 8'h00);
        step();
        check("mid_after_out_valid", {7'b0, OUT_VALID}, 8'h00);
        check("mid_after_result", RESULT, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_shift_mul_unit.md
Name: alu_shift_mul_unit

Overview:
- Registered 8-bit arithmetic/shift unit for the single-cycle processor ALU path.
- Computes one of four operations on DATA1/DATA2, selected by OP: multiply (low byte), logical shift left, arithmetic shift right, rotate right.
- Result and ZERO flag are registered with 1-cycle latency, qualified by a valid pulse.

Parameters:
- WIDTH, 8, operand/result width; only 8 is required to be supported.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operands/OP sampled on this CLK edge when high.
- OP  input  2  00 MULT, 01 SL, 10 SRA, 11 ROR.
- DATA1  input  8  operand; multiplicand, or the value to shift/rotate.
- DATA2  input  8  operand; multiplier, or the unsigned shift amount.
- RESULT  output  8  registered result.
- ZERO  output  1  registered; 1 when RESULT == 0.
- OUT_VALID  output  1  high for exactly one cycle, the cycle after IN_VALID.

Behaviour:
- Reset: on a CLK edge with RESET=1, RESULT=8'h00, ZERO=1, OUT_VALID=0. RESET has priority over IN_VALID on the same edge.
- Latency: IN_VALID sampled at edge N gives RESULT/ZERO/OUT_VALID at edge N (visible after N), and OUT_VALID deasserts at edge N+1 unless IN_VALID is high again.
- Throughput: one operation per cycle; back-to-back IN_VALID is allowed with no stall.
- Hold: when IN_VALID=0, RESULT and ZERO hold their last values.
- MULT: RESULT = (DATA1 * DATA2)[7:0].
  - The low byte is identical for signed and unsigned operands, so no sign handling is needed.
  - Overflow bits above bit 7 are discarded.
- SL (logical left):
  - RESULT = DATA1 << DATA2, zero fill.
  - If DATA2 >= 8 (any of DATA2[7:3] set), RESULT = 0.
- SRA (arithmetic right):
  - RESULT = DATA1 >>> DATA2, filled with DATA1[7].
  - If DATA2 >= 8, RESULT = {8{DATA1[7]}}.
- ROR (rotate right):
  - Amount = DATA2[2:0], i.e. modulo 8; upper bits are ignored.
  - Amount 0 gives RESULT = DATA1.
- Shift amount 0 returns DATA1 unchanged for SL and SRA.
- ZERO is computed from the value being loaded into RESULT and registered in the same edge; it is never derived from the old RESULT.
- Datapath: all computation is combinational between the input sample and the output register. No internal multi-cycle state and no FSM.
- Reset mid-stream: an IN_VALID coinciding with RESET is dropped; no OUT_VALID follows it.

Decomposition:
- Shared package alu_pkg:
  - OP encoding constants OP_MULT=2'b00, OP_SL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11.
  - WIDTH constant = 8.
- Sub-module right_shifter8: 3-stage barrel shifter (1/2/4) plus a >=8 saturate stage.
  - Has a ROTATE control input: ROTATE=0 selects SRA (sign fill), ROTATE=1 selects ROR.
  - Instantiated once and shared by the SRA and ROR ops.
- Left shift is an inline 3-stage barrel (zero fill plus >=8 clear).
- Multiplier is an inline 8x8 shift-and-add partial-product array, truncated to 8 bits.

Test Plan:
- Reset with RESET=1 for 2 cycles while IN_VALID=1 -> RESULT=00, ZERO=1, OUT_VALID=0; after release, no stray OUT_VALID.
- MULT:
  - 05*03 -> 0F, ZERO=0.
  - FE*03 -> FA (-6).
  - 10*10 -> 00, ZERO=1.
  - FF*FF -> 01.
- SL:
  - 81 by 1 -> 02.
  - 01 by 7 -> 80.
  - 5A by 0 -> 5A.
  - FF by 8 -> 00, ZERO=1.
  - FF by 200 -> 00.
- SRA:
  - 80 by 2 -> E0.
  - 7F by 3 -> 0F.
  - 80 by 9 -> FF.
  - 40 by 8 -> 00, ZERO=1.
- ROR:
  - 01 by 1 -> 80.
  - A5 by 4 -> 5A.
  - 01 by 9 -> 80 (mod 8).
  - 3C by 8 -> 3C.
- Pipelining: IN_VALID on 3 consecutive cycles (MULT 02*03, SL 01 by 2, ROR 02 by 1).
  - OUT_VALID is high for 3 consecutive cycles with RESULT 06, 04, 01.
  - With IN_VALID low afterwards, RESULT holds 01 and OUT_VALID drops.
